hazard_scoreboard: RTL

//  Producer-side companion to the EX-stage forwarding unit: decides when ID must stall rather than forward.
//  - Detects load-use hazards against EX.
//  - Keeps a scoreboard of registers owed by the long-latency unit (mul/div), which forwarding cannot cover.
//  - Sits between the ID stage and the IF/ID and ID/EX pipeline registers.
//  - Drives Stall (hold PC and IF/ID) and Bubble (zero ID/EX control).

---
 rtl/hazard_scoreboard_if.sv | 35 +++
 rtl/hazard_scoreboard.sv | 90 +++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID/EX/long-unit signals seen by the hazard scoreboard, plus its stall and status outputs.
// master drives the pipeline side; slave is the scoreboard itself.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 3
);
  logic             ID_valid;
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic [4:0]       ID_rd;
  logic             ID_regwrite;
  logic             ID_longop;
  logic [4:0]       EX_rd;
  logic             EX_memread;
  logic             LU_done;
  logic [4:0]       LU_rd;
  logic             Stall;
  logic             Bubble;
  logic [31:0]      Pending_mask;
  logic [CNT_W-1:0] Pending_cnt;
  logic             Err;

  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd, ID_regwrite, ID_longop,
    output EX_rd, EX_memread, LU_done, LU_rd,
    input  Stall, Bubble, Pending_mask, Pending_cnt, Err
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd, ID_regwrite, ID_longop,
    input  EX_rd, EX_memread, LU_done, LU_rd,
    output Stall, Bubble, Pending_mask, Pending_cnt, Err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage stall decision: load-use against EX plus a scoreboard of registers owed by the mul/div unit.
// Stall/Bubble are combinational in the same cycle; scoreboard state updates on the next rising edge.
module hazard_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [31:0]      lu_rd_oh;
  logic [31:0]      set_oh;
  logic [31:0]      mask_eff;
  logic [CNT_W-1:0] cnt_eff;
  logic             retire;
  logic             lu_err;
  logic             hz_lu, hz_raw, hz_waw, hz_full;
  logic             stall;
  logic             issue;

  // A completion is legal only when something is in flight; rd=0 ops own no mask bit.
  always_comb begin
    lu_rd_oh = 32'd1 << bus.LU_rd;
    retire   = bus.LU_done && (cnt_q != CNT_ZERO) &&
               ((bus.LU_rd == 5'd0) || mask_q[bus.LU_rd]);
    lu_err   = bus.LU_done && !retire;
  end

  // Same-cycle bypass: the register being written back is no longer a hazard.
  always_comb begin
    mask_eff = retire ? (mask_q & ~lu_rd_oh) : mask_q;
    cnt_eff  = retire ? (cnt_q - CNT_ONE) : cnt_q;
  end

  always_comb begin
    hz_lu   = bus.EX_memread && (bus.EX_rd != 5'd0) &&
              ((bus.ID_use_rs1 && (bus.EX_rd == bus.ID_rs1)) ||
               (bus.ID_use_rs2 && (bus.EX_rd == bus.ID_rs2)));
    hz_raw  = (bus.ID_use_rs1 && mask_eff[bus.ID_rs1]) ||
              (bus.ID_use_rs2 && mask_eff[bus.ID_rs2]);
    hz_waw  = bus.ID_regwrite && mask_eff[bus.ID_rd];
    hz_full = bus.ID_longop && (cnt_eff == CNT_MAX);
    stall   = rst_n && bus.ID_valid && (hz_lu || hz_raw || hz_waw || hz_full);
    issue   = bus.ID_valid && bus.ID_longop && !stall;
  end

  // Set is applied after the clear so an issue and a retire to the same register keep the bit.
  always_comb begin
    set_oh = (issue && (bus.ID_rd != 5'd0)) ? (32'd1 << bus.ID_rd) : 32'd0;
    mask_d = (mask_eff | set_oh) & ~32'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue, retire})
      2'b10:   cnt_d = (cnt_q == CNT_MAX)  ? cnt_q : (cnt_q + CNT_ONE);
      2'b01:   cnt_d = (cnt_q == CNT_ZERO) ? cnt_q : (cnt_q - CNT_ONE);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q || lu_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= 32'd0;
      cnt_q  <= CNT_ZERO;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.Stall        = stall;
  assign bus.Bubble       = stall;
  assign bus.Pending_mask = mask_q;
  assign bus.Pending_cnt  = cnt_q;
  assign bus.Err          = err_q;

endmodule
